// File: rtl/r2l_exp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r2l_exp_pkg
// Description : Shared types and constants for the right-to-left exponentiator.
// Revision    : 1.0
// ============================================================================
package r2l_exp_pkg;

    localparam int c_k = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/r2l_datapath.sv
`default_nettype none
// ============================================================================
// Module      : r2l_datapath
// Description : Accumulator, running square and exponent registers plus the
//               two truncating multipliers of the square-and-multiply loop.
// Revision    : 1.0
// ============================================================================
module r2l_datapath
    import r2l_exp_pkg::*;
#(
    parameter int K = c_k
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [K-1:0]     i_a,
    input  logic [K-1:0]     i_b,
    output logic [2*K-1:0]   o_r_next,
    output logic             o_e_last
);

    logic [2*K-1:0] r_r;
    logic [2*K-1:0] r_s;
    logic [K-1:0]   r_e;

    logic [2*K-1:0] w_rs;
    logic [2*K-1:0] w_ss;
    logic [2*K-1:0] w_r_next;
    logic [K-1:0]   w_e_shift;

    // Products are sized to 2K bits so the high half is dropped.
    assign w_rs      = r_r * r_s;
    assign w_ss      = r_s * r_s;
    assign w_e_shift = r_e >> 1;

    always_comb begin
        w_r_next = r_r;
        if (i_load) begin
            w_r_next = {{(2*K-1){1'b0}}, 1'b1};
        end else if (i_step && r_e[0]) begin
            w_r_next = w_rs;
        end
    end

    // The control block captures the result from the next-state value so C
    // is already valid in the cycle Done is raised.
    assign o_r_next = w_r_next;
    assign o_e_last = (w_e_shift == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= '0;
            r_s <= '0;
            r_e <= '0;
        end else begin
            r_r <= w_r_next;
            if (i_load) begin
                r_s <= {{K{1'b0}}, i_a};
                r_e <= i_b;
            end else if (i_step) begin
                r_s <= w_ss;
                r_e <= w_e_shift;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/r2l_exp.sv
`default_nettype none
// ============================================================================
// Module      : r2l_exp
// Description : Computes C = A^B mod 2^(2k) by LSB-first square-and-multiply.
// Revision    : 1.0
// ============================================================================
module r2l_exp
    import r2l_exp_pkg::*;
#(
    parameter int k = c_k
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [k-1:0]   A,
    input  logic [k-1:0]   B,
    output logic [2*k-1:0] C,
    output logic           Done
);

    state_e         r_state;
    state_e         w_state_next;
    logic           w_load;
    logic           w_step;
    logic           w_e_last;
    logic [2*k-1:0] w_r_next;
    logic [2*k-1:0] r_c;

    r2l_datapath #(
        .K (k)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_a      (A),
        .i_b      (B),
        .o_r_next (w_r_next),
        .o_e_last (w_e_last)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_e_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_c     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == DONE) begin
                r_c <= w_r_next;
            end
        end
    end

    assign C    = r_c;
    assign Done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_r2l_exp.sv
`default_nettype none
// ============================================================================
// Module      : tb_r2l_exp
// Description : Directed and random self-checking bench for r2l_exp.
// Revision    : 1.0
// ============================================================================
module tb_r2l_exp;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] C;
    logic        Done;

    int n_checks;
    int n_errors;

    r2l_exp #(
        .k (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .Done  (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Left-to-right reference, independent of the DUT's LSB-first ordering.
    function automatic logic [31:0] ref_pow(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 15; i >= 0; i--) begin
            r = r * r;
            if (b[i]) r = r * {16'd0, a};
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [15:0] b);
        int m;
        m = -1;
        for (int i = 0; i < 16; i++) if (b[i]) m = i;
        return (b == 16'd0) ? 1 : m + 2;
    endfunction

    // Pulses start for one edge and returns latency (edges incl. the accepting
    // one) and C at the first Done-high cycle; lat = -1 on timeout.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [31:0] c);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!Done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        c = C;
        if (!Done) lat = -1;
        @(posedge clk); #1;
        check("done_width", {63'd0, Done}, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] c;
        logic [8:0]  mask;
        logic        seen;
        logic [15:0] ra;
        logic [15:0] rb;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_c", {32'd0, C}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);

        run_op(16'd3, 16'd5, lat, c);
        check("3^5_lat", 64'(lat), 64'd4);
        check("3^5_c", {32'd0, c}, 64'd243);

        run_op(16'd2, 16'd0, lat, c);
        check("2^0_lat", 64'(lat), 64'd1);
        check("2^0_c", {32'd0, c}, 64'd1);

        run_op(16'd0, 16'd3, lat, c);
        check("0^3_lat", 64'(lat), 64'd3);
        check("0^3_c", {32'd0, c}, 64'd0);

        run_op(16'd2, 16'd40, lat, c);
        check("2^40_lat", 64'(lat), 64'd7);
        check("2^40_c", {32'd0, c}, 64'd0);

        run_op(16'hFFFF, 16'd1, lat, c);
        check("ffff^1_lat", 64'(lat), 64'd2);
        check("ffff^1_c", {32'd0, c}, 64'h0000FFFF);

        // Second start pulsed during RUN must be dropped.
        @(negedge clk);
        A = 16'd3; B = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        A = 16'd7; B = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!Done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ignore_lat", 64'(lat), 64'd4);
        check("ignore_c", {32'd0, C}, 64'd243);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | Done;
        end
        check("ignore_no_extra", {63'd0, seen}, 64'd0);

        // Reset in the second RUN cycle aborts without a Done pulse.
        @(negedge clk);
        A = 16'd3; B = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_c", {32'd0, C}, 64'd0);
        check("abort_done", {63'd0, Done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | Done;
        end
        check("abort_no_done", {63'd0, seen}, 64'd0);
        run_op(16'd5, 16'd3, lat, c);
        check("5^3_lat", 64'(lat), 64'd3);
        check("5^3_c", {32'd0, c}, 64'd125);

        // start held high: a new operation begins in every IDLE cycle.
        @(negedge clk);
        A = 16'd3; B = 16'd1; start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            mask[i] = Done;
        end
        start = 1'b0;
        check("b2b_pattern", {55'd0, mask}, 64'h092);
        check("b2b_c", {32'd0, C}, 64'd3);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 16'd2; B = 16'd0;
        @(posedge clk); #1;
        check("rst_prio_done", {63'd0, Done}, 64'd0);
        check("rst_prio_c", {32'd0, C}, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 16);
            run_op(ra, rb, lat, c);
            check("sweep_lat", 64'(lat), 64'(ref_lat(rb)));
            check("sweep_c", {32'd0, c}, {32'd0, ref_pow(ra, rb)});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
